// File: rtl/dice_pkg.sv
// Shared definitions for the electronic dice and its scorer: FSM states and die face limits.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        CAPTURE,
        OVER
    } state_t;

    localparam int THROW_W = 3;
    localparam int DIE_MIN = 1;
    localparam int DIE_MAX = 6;

    function automatic logic throw_valid(input logic [THROW_W-1:0] t);
        return (t >= THROW_W'(DIE_MIN)) && (t <= THROW_W'(DIE_MAX));
    endfunction

endpackage

// File: rtl/dice_scorer_if.sv
// Button/dice inputs and score/status outputs of the dice scorer.
interface dice_scorer_if #(
    parameter int SCORE_W = 6,
    parameter int CNT_W   = 4
);
    import dice_pkg::*;

    logic               button;
    logic [THROW_W-1:0] throw;
    logic               new_game;
    logic               roll_done;
    logic [THROW_W-1:0] last_throw;
    logic [SCORE_W-1:0] total;
    logic [CNT_W-1:0]   rolls;
    logic               illegal;
    logic               win;
    logic               lose;

    modport master (
        output button, throw, new_game,
        input  roll_done, last_throw, total, rolls, illegal, win, lose
    );

    modport slave (
        input  button, throw, new_game,
        output roll_done, last_throw, total, rolls, illegal, win, lose
    );

endinterface

// File: rtl/btn_fall_detect.sv
// Registers the roll button and flags the cycle in which it is seen going from high to low.
module btn_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_fall
);
    logic r_btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_btn <= 1'b0;
        else     r_btn <= i_btn;
    end

    assign o_fall = r_btn & ~i_btn;

endmodule

// File: rtl/dice_scorer.sv
// Scores settled dice throws on each button release and ends the game on a win or a loss.
module dice_scorer
    import dice_pkg::*;
#(
    parameter int TARGET    = 21,
    parameter int MAX_ROLLS = 8,
    parameter int SCORE_W   = 6,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    dice_scorer_if.slave  bus
);
    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_total, w_total_nxt;
    logic [CNT_W-1:0]   r_rolls, w_rolls_nxt;
    logic [THROW_W-1:0] r_last, w_last_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic               r_win, w_win_nxt;
    logic               r_lose, w_lose_nxt;
    logic               r_done, w_done_nxt;

    logic               w_fall;
    logic [SCORE_W:0]   w_sum;
    logic [CNT_W-1:0]   w_rolls_inc;

    btn_fall_detect u_fall (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (bus.button),
        .o_fall (w_fall)
    );

    // One extra bit so a last roll landing above TARGET can never wrap below it
    assign w_sum       = {1'b0, r_total} + {{(SCORE_W + 1 - THROW_W){1'b0}}, bus.throw};
    assign w_rolls_inc = r_rolls + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_total_nxt   = r_total;
        w_rolls_nxt   = r_rolls;
        w_last_nxt    = r_last;
        w_illegal_nxt = r_illegal;
        w_win_nxt     = r_win;
        w_lose_nxt    = r_lose;
        w_done_nxt    = 1'b0;

        if (bus.new_game) begin
            w_state_nxt   = IDLE;
            w_total_nxt   = '0;
            w_rolls_nxt   = '0;
            w_last_nxt    = '0;
            w_illegal_nxt = 1'b0;
            w_win_nxt     = 1'b0;
            w_lose_nxt    = 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (bus.button) w_state_nxt = ROLLING;
                ROLLING: if (w_fall)     w_state_nxt = CAPTURE;
                CAPTURE: begin
                    if (throw_valid(bus.throw)) begin
                        w_total_nxt = w_sum[SCORE_W-1:0];
                        w_rolls_nxt = w_rolls_inc;
                        w_last_nxt  = bus.throw;
                        w_done_nxt  = 1'b1;
                        // Reaching the target on the final allowed roll counts as a win
                        if (w_sum >= (SCORE_W + 1)'(TARGET)) begin
                            w_win_nxt   = 1'b1;
                            w_state_nxt = OVER;
                        end else if (w_rolls_inc == CNT_W'(MAX_ROLLS)) begin
                            w_lose_nxt  = 1'b1;
                            w_state_nxt = OVER;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
                OVER:    w_state_nxt = OVER;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_total   <= '0;
            r_rolls   <= '0;
            r_last    <= '0;
            r_illegal <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_total   <= w_total_nxt;
            r_rolls   <= w_rolls_nxt;
            r_last    <= w_last_nxt;
            r_illegal <= w_illegal_nxt;
            r_win     <= w_win_nxt;
            r_lose    <= w_lose_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.roll_done  = r_done;
    assign bus.last_throw = r_last;
    assign bus.total      = r_total;
    assign bus.rolls      = r_rolls;
    assign bus.illegal    = r_illegal;
    assign bus.win        = r_win;
    assign bus.lose       = r_lose;

endmodule

// File: tb/tb_dice_scorer.sv
// Scoreboard bench for dice_scorer: game-rule reference model, roll_done-driven monitor, dice stand-in.
module tb_dice_scorer;

    localparam int TARGET    = 21;
    localparam int MAX_ROLLS = 8;
    localparam int SCORE_W   = 6;
    localparam int CNT_W     = 4;

    typedef struct {
        int total;
        int rolls;
        int last;
        int win;
        int lose;
        int ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       use_dice = 1'b0;
    logic [2:0] drv_throw = 3'd0;
    logic [2:0] dice;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    int m_total, m_rolls, m_last, m_win, m_lose, m_ill, m_over, m_die;

    dice_scorer_if #(.SCORE_W(SCORE_W), .CNT_W(CNT_W)) bus ();

    dice_scorer #(
        .TARGET    (TARGET),
        .MAX_ROLLS (MAX_ROLLS),
        .SCORE_W   (SCORE_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the electronic dice: cycles 1..6 while the button is held
    always @(posedge clk or posedge rst) begin
        if (rst)             dice <= 3'd1;
        else if (bus.button) dice <= (dice == 3'd6) ? 3'd1 : dice + 3'd1;
    end

    assign bus.throw = use_dice ? dice : drv_throw;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        m_total = 0; m_rolls = 0; m_last = 0;
        m_win = 0; m_lose = 0; m_ill = 0; m_over = 0;
    endtask

    task automatic model_roll(input int v);
        exp_t e;
        if (m_over != 0) return;
        if (v >= 1 && v <= 6) begin
            m_total += v;
            m_rolls++;
            m_last = v;
            if (m_total >= TARGET) begin
                m_win = 1; m_over = 1;
            end else if (m_rolls == MAX_ROLLS) begin
                m_lose = 1; m_over = 1;
            end
            e.total = m_total; e.rolls = m_rolls; e.last = m_last;
            e.win = m_win; e.lose = m_lose; e.ill = m_ill;
            exp_q.push_back(e);
        end else begin
            m_ill = 1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".total"},   int'(bus.total),      m_total);
        chk({tag, ".rolls"},   int'(bus.rolls),      m_rolls);
        chk({tag, ".last"},    int'(bus.last_throw), m_last);
        chk({tag, ".illegal"}, int'(bus.illegal),    m_ill);
        chk({tag, ".win"},     int'(bus.win),        m_win);
        chk({tag, ".lose"},    int'(bus.lose),       m_lose);
        chk({tag, ".done"},    int'(bus.roll_done),  0);
    endtask

    task automatic press(input int len, input int v);
        int val;
        @(negedge clk);
        bus.button = 1'b1;
        repeat (len) @(negedge clk);
        bus.button = 1'b0;
        if (use_dice) begin
            m_die = ((m_die - 1 + len) % 6) + 1;
            val = m_die;
        end else begin
            drv_throw = v[2:0];
            val = v;
        end
        model_roll(val);
        repeat (3) @(negedge clk);
        chk("roll_done_latency", exp_q.size(), 0);
    endtask

    task automatic new_game_pulse();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        model_clear();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.roll_done) begin
            if (exp_q.size() == 0) begin
                chk("roll_done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mon.total", int'(bus.total),      e.total);
                chk("mon.rolls", int'(bus.rolls),      e.rolls);
                chk("mon.last",  int'(bus.last_throw), e.last);
                chk("mon.win",   int'(bus.win),        e.win);
                chk("mon.lose",  int'(bus.lose),       e.lose);
                chk("mon.ill",   int'(bus.illegal),    e.ill);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.button   = 1'b0;
        bus.new_game = 1'b0;
        model_clear();
        m_die = 1;
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b0;

        // Single roll
        press(3, 4);
        check_state("t1");

        // Win on 6,6,6,3 then presses are ignored
        new_game_pulse();
        press(2, 6); press(1, 6); press(4, 6); press(2, 3);
        check_state("t2_win");
        press(2, 5); press(4, 6);
        check_state("t2_over");

        // Illegal captures
        new_game_pulse();
        press(1, 7);
        check_state("t3_seven");
        press(2, 0);
        press(3, 2);
        check_state("t3_after");

        // Loss after eight ones, then clear
        new_game_pulse();
        for (int i = 0; i < 8; i++) press(1 + (i % 3), 1);
        check_state("t4_lose");
        new_game_pulse();
        check_state("t4_clear");

        // Target reached exactly on the final roll: win beats lose
        for (int i = 0; i < 6; i++) press(2, 3);
        press(1, 1); press(1, 2);
        check_state("t4_win_last");

        // new_game coinciding with the capture cycle
        new_game_pulse();
        press(1, 2);
        @(negedge clk); bus.button = 1'b1;
        @(negedge clk); bus.button = 1'b0; drv_throw = 3'd5;
        @(negedge clk); bus.new_game = 1'b1;
        @(negedge clk); bus.new_game = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_state("t5_ng_capture");

        // Asynchronous reset while rolling
        press(2, 3);
        @(negedge clk); bus.button = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check_state("t5_rst");
        @(negedge clk); bus.button = 1'b0;
        @(negedge clk); rst = 1'b0;
        press(1, 6);
        check_state("t5_after_rst");

        // Integration with the dice stand-in, random press lengths
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
        m_die = 1;
        use_dice = 1'b1;
        check_state("t6_start");
        for (int i = 0; i < 30; i++) begin
            if (m_over != 0) new_game_pulse();
            press(int'($urandom_range(20, 1)), 0);
        end
        check_state("t6_end");

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
